// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU finish in a single step.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`ifdef MULDIV_FAST_MUL_EN
    localparam logic [CW-1:0] MUL_LAST = {CW{1'b0}};
`else
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
`endif
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_signed_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s, mul_prod_s, mul_res_s;
    logic [WIDTH:0]     div_rem_sh_s, div_trial_s;
    logic [2*WIDTH-1:0] div_next_s;

    assign is_signed_s = ~op[0];
    assign mag_a_s     = neg_if(a, is_signed_s & a[WIDTH-1]);
    assign mag_b_s     = neg_if(b, is_signed_s & b[WIDTH-1]);

    // acc holds {partial product, remaining multiplier bits} for MUL and {remainder, quotient/dividend} for DIV
    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
`ifdef MULDIV_FAST_MUL_EN
    assign mul_prod_s = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, mb_q};
`else
    assign mul_prod_s = mul_next_s;
`endif
    assign mul_res_s    = neg2_if(mul_prod_s, neg_res_q);
    assign div_rem_sh_s = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial_s  = div_rem_sh_s - {1'b0, mb_q};
    assign div_next_s   = div_trial_s[WIDTH] ? {div_rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                             : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Next-state, iteration step and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mb_d      = mb_q;
        a_raw_d   = a_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    state_d   = op[1] ? S_DIV : S_MUL;
                    cnt_d     = {CW{1'b0}};
                    acc_d     = {{WIDTH{1'b0}}, mag_a_s};
                    mb_d      = mag_b_s;
                    a_raw_d   = a;
                    neg_res_d = is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed_s & a[WIDTH-1];
                    div0_d    = (b == {WIDTH{1'b0}});
                end else begin
                    if (wr_hi) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (wr_lo) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_IDLE;
                    hi_d    = mul_res_s[2*WIDTH-1:WIDTH];
                    lo_d    = mul_res_s[WIDTH-1:0];
                    done_d  = 1'b1;
                end else begin
                    acc_d = mul_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (div0_q) begin
                        hi_d = a_raw_q;
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        hi_d = neg_if(div_next_s[2*WIDTH-1:WIDTH], neg_rem_q);
                        lo_d = neg_if(div_next_s[WIDTH-1:0], neg_res_q);
                    end
                end else begin
                    acc_d = div_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            mb_q      <= {WIDTH{1'b0}};
            a_raw_q   <= {WIDTH{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mb_q      <= mb_d;
            a_raw_q   <= a_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
